// File: rtl/interrupt_dispatch.sv
// interrupt_dispatch: prioritised interrupt redirect unit for a PC mux.
// Detects request edges, picks the highest-priority enabled line, saves the
// return PC and running level on a nesting stack, and drives the redirect.
// Optional feature macro: INTERRUPT_NESTING_EN (multi-level preemption up to
// Depth; without it a single stack entry is used and nesting is blocked).

package interrupt_dispatch_pkg;
    typedef enum logic {
        PC_NORMAL    = 1'b0,
        PC_INTERRUPT = 1'b1
    } pc_interrupt_mux_t;
endpackage

module interrupt_dispatch
    import interrupt_dispatch_pkg::*;
#(
    parameter int AddrWidth = 32,
    parameter int NumIrq    = 8,
    parameter int PrioWidth = 3,
    parameter int Depth     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NumIrq-1:0]             irq_req,
    input  logic [NumIrq-1:0]             irq_en,
    input  logic [NumIrq*PrioWidth-1:0]   irq_prio,
    input  logic                          global_ie,
    input  logic [AddrWidth-1:0]          vec_base,
    input  logic [AddrWidth-1:0]          pc_normal,
    input  logic                          stall,
    input  logic                          mret,
    output pc_interrupt_mux_t             sel,
    output logic [AddrWidth-1:0]          pc_interrupt,
    output logic                          irq_take,
    output logic [$clog2(NumIrq)-1:0]     irq_id,
    output logic [PrioWidth-1:0]          level,
    output logic [$clog2(Depth):0]        depth
);

    localparam int unsigned IdW = $clog2(NumIrq);
    localparam int unsigned DW  = $clog2(Depth) + 1;
`ifdef INTERRUPT_NESTING_EN
    localparam int unsigned StackN = Depth;
`else
    localparam int unsigned StackN = 1;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_IRQ  = 2'd1;
    localparam logic [1:0] ST_RET  = 2'd2;

    logic [1:0]           state;
    logic [NumIrq-1:0]    irq_prev;
    logic [NumIrq-1:0]    pending;
    logic [NumIrq-1:0]    edges;
    logic [NumIrq-1:0]    pend_eff;
    logic [NumIrq-1:0]    clr;
    logic [AddrWidth-1:0] stk_pc  [StackN];
    logic [PrioWidth-1:0] stk_lvl [StackN];
    logic [IdW-1:0]       best_id;
    logic [PrioWidth-1:0] best_prio;
    logic [DW-1:0]        depth_m1;
    logic [AddrWidth-1:0] pop_pc;
    logic [PrioWidth-1:0] pop_lvl;
    logic                 do_pop;
    logic                 do_push;

    // A rising edge seen this cycle is already a candidate (1-cycle latency).
    assign edges    = irq_req & ~irq_prev;
    assign pend_eff = pending | edges;
    assign depth_m1 = depth - 1'b1;

    assign do_pop  = (state == ST_IDLE) && mret && (depth != '0);
    assign do_push = !do_pop && global_ie && (state == ST_IDLE) &&
                     (best_prio > level) && (depth < DW'(StackN));
    assign clr     = do_push ? (NumIrq'(1) << best_id) : '0;

    assign sel      = (state == ST_IDLE) ? PC_NORMAL : PC_INTERRUPT;
    assign irq_take = (state == ST_IRQ) && !stall;

    // Candidate: highest nonzero priority among pending enabled lines, ties to lowest index.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int unsigned i = 0; i < NumIrq; i++) begin
            if (pend_eff[i] && irq_en[i] &&
                (irq_prio[i*PrioWidth +: PrioWidth] > best_prio)) begin
                best_id   = IdW'(i);
                best_prio = irq_prio[i*PrioWidth +: PrioWidth];
            end
        end
    end

    // Top-of-stack read for the return path.
    always_comb begin
        pop_pc  = '0;
        pop_lvl = '0;
        for (int unsigned i = 0; i < StackN; i++) begin
            if (DW'(i) == depth_m1) begin
                pop_pc  = stk_pc[i];
                pop_lvl = stk_lvl[i];
            end
        end
    end

    // Edge history and pending latch; a new edge on an already-pending line survives its clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_prev <= '0;
            pending  <= '0;
        end else begin
            irq_prev <= irq_req;
            pending  <= (pending & ~clr) | (edges & ~(clr & ~pending));
        end
    end

    // Nesting stack: push return PC and running level on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < StackN; i++) begin
                stk_pc[i]  <= '0;
                stk_lvl[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < StackN; i++) begin
                if (do_push && (DW'(i) == depth)) begin
                    stk_pc[i]  <= pc_normal;
                    stk_lvl[i] <= level;
                end
            end
        end
    end

    // Dispatch FSM: IDLE takes or returns, IRQ/RET hold the redirect until not stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            pc_interrupt <= '0;
            irq_id       <= '0;
            level        <= '0;
            depth        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (do_pop) begin
                        depth        <= depth_m1;
                        level        <= pop_lvl;
                        pc_interrupt <= pop_pc;
                        state        <= ST_RET;
                    end else if (do_push) begin
                        depth        <= depth + 1'b1;
                        level        <= best_prio;
                        irq_id       <= best_id;
                        pc_interrupt <= vec_base + (AddrWidth'(best_id) << 2);
                        state        <= ST_IRQ;
                    end
                end
                ST_IRQ, ST_RET: begin
                    if (!stall) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
